pjon_frame_builder: RTL and testbench
=====================================

PJON_FRAME_BUILDER -- requirements
Module: pjon_frame_builder

Interface
REQ-001 SHALL have parameter MaxPayload, default 10, meaning the maximum number of payload bytes per frame (range 1..10).
REQ-002 SHALL have parameter axis_req_t, default logic, meaning the AXI-stream request type (8-bit data, last, keep, strb, user[1:0]).
REQ-003 SHALL have parameter axis_rsp_t, default logic, meaning the AXI-stream response type (tready).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port axis_payload_req_i  in  axis_req_t  payload bytes from the wrapper; last marks the final byte.
REQ-007 SHALL have port axis_payload_rsp_o  out  axis_rsp_t  tready toward the wrapper.
REQ-008 SHALL have port axis_frame_req_o  out  axis_req_t  framed bytes toward pjdl send.
REQ-009 SHALL have port axis_frame_rsp_i  in  axis_rsp_t  tready from pjdl.
REQ-010 SHALL have port receiver_id_i  in  8  PJON receiver ID, sampled on the first payload beat.
REQ-011 SHALL have port ack_request_i  in  1  request a synchronous ACK, sampled on the first payload beat.
REQ-012 SHALL have port ack_timeout_i  in  8  ACK-request repetition count, sampled on the first payload beat.
REQ-013 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-014 SHALL have port frame_error_o  out  1  one-cycle pulse when a frame is dropped.

Function
REQ-015 The block SHALL use the states IDLE, COLLECT, ID, BITMAP, LEN, HCRC, PAYLOAD, TCRC, ACKREQ and DROP.
REQ-016 The block SHALL store payload bytes in an internal buffer of MaxPayload entries, with a count register n of width clog2(MaxPayload+1).
REQ-017 IDLE -> COLLECT on the first accepted payload beat; that beat SHALL be stored and receiver_id_i, ack_request_i and ack_timeout_i SHALL be latched.
REQ-018 In IDLE and COLLECT, axis_payload_rsp_o.tready SHALL be 1; in all other states except DROP it SHALL be 0.
REQ-019 When an accepted beat has last=1 and total n is at most MaxPayload, the block SHALL go to ID on the next cycle; a single-beat frame SHALL go IDLE -> ID directly.
REQ-020 When a beat is accepted while n already equals MaxPayload, the block SHALL go to DROP; the beat SHALL NOT be stored.
REQ-021 In DROP, tready SHALL be 1 and all beats SHALL be discarded up to and including the beat with last=1.
REQ-022 On that last beat, frame_error_o SHALL pulse for one cycle, the buffer SHALL clear, the block SHALL return to IDLE, and no output beat SHALL be produced.
REQ-023 Output byte order SHALL be: ID=receiver_id; BITMAP = 8'h04 if ACK is requested, else 8'h00; LEN = n+5 (8-bit); HCRC = crc8(ID, BITMAP, LEN); then the n payload bytes; then TCRC = crc8 over all preceding frame bytes.
REQ-024 crc8 SHALL be the PJON CRC8: init 0x00, LSB-first, polynomial 0x97 reflected; for each bit, crc = (crc>>1) ^ (((crc^b)&1) ? 0x97 : 0).
REQ-025 A running CRC SHALL be updated on each handshake and reset at HCRC to continue over HCRC itself.
REQ-026 Each output state SHALL drive tvalid=1, keep=1, strb=1, user=2'b00 and last=0, except TCRC, which SHALL drive last=1.
REQ-027 The block SHALL advance to the next state only on tvalid & tready.
REQ-028 tvalid, data, last and user SHALL remain stable while tready=0.
REQ-029 PAYLOAD SHALL step a read pointer from 0 to n-1.
REQ-030 After TCRC, the block SHALL go to ACKREQ if ACK was latched, else to IDLE.
REQ-031 ACKREQ SHALL drive data=latched ack_timeout, user=2'b10, last=1; on handshake it SHALL go to IDLE.
REQ-032 Latency SHALL be one cycle from acceptance of the last payload beat to the ID beat being valid, and zero idle cycles between output beats when tready is held at 1.
REQ-033 New payload SHALL NOT be accepted until the block returns to IDLE; back-to-back frames SHALL insert exactly one IDLE cycle.

Reset
REQ-034 While rst_n=1, the block SHALL set the state to IDLE and n, read pointer, CRC and latched fields to 0.
REQ-035 While rst_n=1, all outputs SHALL be 0: tvalid, tready, busy_o, frame_error_o, and data/last/user.
REQ-036 Reset mid-frame SHALL discard the partial frame with no error pulse; the first cycle after release SHALL be IDLE with tready=1.

Verification
REQ-037 Payload 8'h41 (last=1), id 8'h01, no ack, tready=1 -> output 01 00 06 54 41 5A with last only on 5A, and no ACKREQ beat.
REQ-038 Payload 01 02 03 F0, ack_request=1, timeout 8'h09 -> bitmap 8'h04, LEN 8'h09, CRCs matching the crc8 software model, then beat data=09 user=2'b10 last=1.
REQ-039 MaxPayload=10 and 11 beats -> no output beats, frame_error_o high for exactly 1 cycle, then the next valid frame is built correctly.
REQ-040 Random tready stalls on the 8'h41 frame -> identical byte sequence, and output is stable on every stalled cycle.
REQ-041 Reset asserted during PAYLOAD -> all outputs 0; after release the 8'h41 frame is built correctly.
REQ-042 Two single-byte frames with payload tvalid held high -> first completes, exactly one IDLE cycle, then the second completes unaltered.

Source files
------------

// File: rtl/pjon_frame_builder.sv
// PJON frame builder: buffers a payload packet from AXI-stream, then emits
// ID, bitmap, length, header CRC, payload, trailer CRC and an optional ACK request.
package pjon_frame_builder_pkg;
    typedef struct packed {
        logic [7:0] tdata;
        logic       tlast;
        logic       tkeep;
        logic       tstrb;
        logic [1:0] tuser;
        logic       tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;
endpackage

module pjon_frame_builder #(
    parameter int unsigned MaxPayload = 10,
    parameter type axis_req_t = pjon_frame_builder_pkg::axis_req_t,
    parameter type axis_rsp_t = pjon_frame_builder_pkg::axis_rsp_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  axis_req_t  axis_payload_req_i,
    output axis_rsp_t  axis_payload_rsp_o,
    output axis_req_t  axis_frame_req_o,
    input  axis_rsp_t  axis_frame_rsp_i,
    input  logic [7:0] receiver_id_i,
    input  logic       ack_request_i,
    input  logic [7:0] ack_timeout_i,
    output logic       busy_o,
    output logic       frame_error_o
);
    localparam int unsigned CntW = $clog2(MaxPayload + 1);

    typedef enum logic [3:0] {
        IDLE, COLLECT, ID, BITMAP, LEN, HCRC, PAYLOAD, TCRC, ACKREQ, DROP
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] n_q, n_d, rptr_q, rptr_d, wr_idx;
    logic [7:0]      crc_q, crc_d, rid_q, rid_d, tmo_q, tmo_d;
    logic            ack_q, ack_d, err_q, err_d, wr_en;
    logic            in_ready, in_hs, out_hs;
    logic [7:0]      pbuf_q [MaxPayload];
    axis_req_t       frame;
    logic            unused_in;

    // PJON CRC8, LSB-first, reflected polynomial 0x97
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 8'h97;
            else                       c = c >> 1;
        end
        return c;
    endfunction

    assign unused_in = ^{axis_payload_req_i.tkeep, axis_payload_req_i.tstrb, axis_payload_req_i.tuser};

    assign in_ready = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DROP);
    assign in_hs    = axis_payload_req_i.tvalid & in_ready;
    assign out_hs   = frame.tvalid & axis_frame_rsp_i.tready;

    // Reset forces tready low even though the decoded state is IDLE
    always_comb begin
        axis_payload_rsp_o        = '0;
        axis_payload_rsp_o.tready = in_ready & ~rst_n;
    end

    assign axis_frame_req_o = frame;
    assign busy_o           = (state_q != IDLE);
    assign frame_error_o    = err_q;

    // Output beat decode; depends only on registered state so it holds during stalls
    always_comb begin
        frame        = '0;
        frame.tvalid = 1'b1;
        case (state_q)
            ID:      frame.tdata = rid_q;
            BITMAP:  frame.tdata = ack_q ? 8'h04 : 8'h00;
            LEN:     frame.tdata = 8'(n_q) + 8'd5;
            HCRC:    frame.tdata = crc_q;
            PAYLOAD: frame.tdata = pbuf_q[rptr_q];
            TCRC: begin
                frame.tdata = crc_q;
                frame.tlast = 1'b1;
            end
            ACKREQ: begin
                frame.tdata = tmo_q;
                frame.tuser = 2'b10;
                frame.tlast = 1'b1;
            end
            default: frame.tvalid = 1'b0;
        endcase
        frame.tkeep = frame.tvalid;
        frame.tstrb = frame.tvalid;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rptr_d  = rptr_q;
        crc_d   = crc_q;
        rid_d   = rid_q;
        ack_d   = ack_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = n_q;
        case (state_q)
            IDLE: if (in_hs) begin
                wr_en   = 1'b1;
                wr_idx  = '0;
                n_d     = CntW'(1);
                rid_d   = receiver_id_i;
                ack_d   = ack_request_i;
                tmo_d   = ack_timeout_i;
                state_d = axis_payload_req_i.tlast ? ID : COLLECT;
            end
            COLLECT: if (in_hs) begin
                if (n_q == CntW'(MaxPayload)) begin
                    // Overflow: a final beat ends the frame here, otherwise drain the rest
                    err_d   = axis_payload_req_i.tlast;
                    state_d = axis_payload_req_i.tlast ? IDLE : DROP;
                end else begin
                    wr_en = 1'b1;
                    n_d   = n_q + CntW'(1);
                    if (axis_payload_req_i.tlast) state_d = ID;
                end
            end
            ID:     if (out_hs) state_d = BITMAP;
            BITMAP: if (out_hs) state_d = LEN;
            LEN:    if (out_hs) state_d = HCRC;
            HCRC:   if (out_hs) state_d = PAYLOAD;
            PAYLOAD: if (out_hs) begin
                rptr_d = rptr_q + CntW'(1);
                if (rptr_q == n_q - CntW'(1)) state_d = TCRC;
            end
            TCRC:   if (out_hs) state_d = ack_q ? ACKREQ : IDLE;
            ACKREQ: if (out_hs) state_d = IDLE;
            DROP: if (in_hs && axis_payload_req_i.tlast) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Running CRC over every emitted byte; after HCRC it restarts from zero implicitly
        if (out_hs) crc_d = crc8_upd(crc_q, frame.tdata);
        if (state_d == IDLE) begin
            n_d    = '0;
            rptr_d = '0;
            crc_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            rptr_q  <= '0;
            crc_q   <= '0;
            rid_q   <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rptr_q  <= rptr_d;
            crc_q   <= crc_d;
            rid_q   <= rid_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) pbuf_q[wr_idx] <= axis_payload_req_i.tdata;
    end
endmodule

// File: tb/tb_pjon_frame_builder.sv
// Scoreboard bench for pjon_frame_builder: expected beats are queued at stimulus
// time and popped on every output handshake.
module tb_pjon_frame_builder;
    import pjon_frame_builder_pkg::*;

    localparam int unsigned MaxPayload = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    axis_req_t  preq, freq;
    axis_rsp_t  prsp, frsp;
    logic [7:0] rid, tmo;
    logic       ack, busy, ferr;

    always #5 clk = ~clk;

    pjon_frame_builder #(
        .MaxPayload(MaxPayload),
        .axis_req_t(axis_req_t),
        .axis_rsp_t(axis_rsp_t)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axis_payload_req_i(preq),
        .axis_payload_rsp_o(prsp),
        .axis_frame_req_o(freq),
        .axis_frame_rsp_i(frsp),
        .receiver_id_i(rid),
        .ack_request_i(ack),
        .ack_timeout_i(tmo),
        .busy_o(busy),
        .frame_error_o(ferr)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] user;
        logic       first;
    } exp_t;

    exp_t expq[$];
    int   total = 0, bad = 0;
    int   cyc = 0, err_pulses = 0, hs_count = 0, gap = 0, last_cyc = 0;
    bit   stall_en = 1'b0;
    bit   have_prev = 1'b0;
    logic [11:0] prev_bits;
    logic        prev_stalled;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] v;
        c = crc;
        v = b;
        for (int i = 0; i < 8; i++) begin
            if (((c ^ v) & 8'h01) != 8'h00) c = (c >> 1) ^ 8'h97;
            else                            c = c >> 1;
            v = v >> 1;
        end
        return c;
    endfunction

    task automatic push_beat(input logic [7:0] d, input logic l, input logic [1:0] u, input logic f);
        exp_t e;
        e.data = d; e.last = l; e.user = u; e.first = f;
        expq.push_back(e);
    endtask

    // Reference framing built from the byte-level definition of the PJON packet
    task automatic push_frame(input logic [7:0] pl[$], input logic [7:0] id, input logic a,
                              input logic [7:0] t);
        logic [7:0] hdr[$];
        logic [7:0] c;
        if (pl.size() > MaxPayload) return;
        hdr = {id, (a ? 8'h04 : 8'h00), 8'(pl.size() + 5)};
        c = 8'h00;
        foreach (hdr[i]) c = crc8(c, hdr[i]);
        hdr.push_back(c);
        foreach (pl[i]) hdr.push_back(pl[i]);
        c = 8'h00;
        foreach (hdr[i]) c = crc8(c, hdr[i]);
        foreach (hdr[i]) push_beat(hdr[i], 1'b0, 2'b00, (i == 0));
        push_beat(c, 1'b1, 2'b00, 1'b0);
        if (a) push_beat(t, 1'b1, 2'b10, 1'b0);
    endtask

    task automatic send(input logic [7:0] pl[$], input logic [7:0] id, input logic a,
                        input logic [7:0] t, input bit hold);
        bit acc;
        int w;
        rid = id; ack = a; tmo = t;
        for (int i = 0; i < pl.size(); i++) begin
            preq.tvalid = 1'b1;
            preq.tdata  = pl[i];
            preq.tlast  = (i == pl.size() - 1);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 300) begin
                @(negedge clk);
                acc = prsp.tready;
                @(posedge clk);
                #1;
                w++;
            end
            if (!acc) check("payload_accept", 32'(acc), 32'd1);
        end
        if (!hold) begin
            preq.tvalid = 1'b0;
            preq.tlast  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (expq.size() != 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({"drain_", tag}, 32'(expq.size()), 32'd0);
        check({"idle_", tag}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_tvalid"}, 32'(freq.tvalid), 32'd0);
        check({tag, "_data"}, {20'd0, freq.tdata, freq.tlast, freq.tuser, freq.tkeep}, 32'd0);
        check({tag, "_tready"}, 32'(prsp.tready), 32'd0);
        check({tag, "_busy_err"}, {30'd0, busy, ferr}, 32'd0);
    endtask

    // Downstream tready, optionally randomly stalled
    initial begin
        frsp = '0;
        forever begin
            @(posedge clk);
            #1;
            frsp.tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output monitor and scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (ferr) err_pulses++;
            if (have_prev && prev_stalled)
                check("stall_stable", {20'd0, freq.tvalid, freq.tdata, freq.tlast, freq.tuser},
                      {20'd0, prev_bits});
            if (freq.tvalid && frsp.tready) begin
                hs_count++;
                if (expq.size() == 0) begin
                    check("unexpected_beat", {24'd0, freq.tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("beat_data", {24'd0, freq.tdata}, {24'd0, e.data});
                    check("beat_last_user", {29'd0, freq.tlast, freq.tuser}, {29'd0, e.last, e.user});
                    if (e.first) gap = cyc - last_cyc;
                    if (e.last) last_cyc = cyc;
                end
            end
            prev_bits    = {freq.tvalid, freq.tdata, freq.tlast, freq.tuser};
            prev_stalled = freq.tvalid && !frsp.tready;
            have_prev    = 1'b1;
        end
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        int e0, h0, w;

        preq = '0;
        preq.tkeep = 1'b1;
        preq.tstrb = 1'b1;
        rid = 8'h00; ack = 1'b0; tmo = 8'h00;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("post_reset_tready", 32'(prsp.tready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Known-answer single-byte frame
        push_beat(8'h01, 1'b0, 2'b00, 1'b1);
        push_beat(8'h00, 1'b0, 2'b00, 1'b0);
        push_beat(8'h06, 1'b0, 2'b00, 1'b0);
        push_beat(8'h54, 1'b0, 2'b00, 1'b0);
        push_beat(8'h41, 1'b0, 2'b00, 1'b0);
        push_beat(8'h5A, 1'b1, 2'b00, 1'b0);
        pl = {8'h41};
        send(pl, 8'h01, 1'b0, 8'h00, 1'b0);
        drain("known41");

        // ACK-requesting frame
        pl = {8'h01, 8'h02, 8'h03, 8'hF0};
        push_frame(pl, 8'h2C, 1'b1, 8'h09);
        send(pl, 8'h2C, 1'b1, 8'h09, 1'b0);
        drain("ack");

        // Full-size frame at the buffer limit
        pl = {};
        for (int i = 0; i < MaxPayload; i++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(pl, 8'h7E, 1'b0, 8'h00);
        send(pl, 8'h7E, 1'b0, 8'h00, 1'b0);
        drain("full");

        // Overflow by one beat, then by several beats
        for (int k = 0; k < 2; k++) begin
            pl = {};
            for (int i = 0; i < MaxPayload + 1 + 2 * k; i++) pl.push_back(8'(i + 8'h30));
            e0 = err_pulses;
            push_frame(pl, 8'h03, 1'b0, 8'h00);
            send(pl, 8'h03, 1'b0, 8'h00, 1'b0);
            repeat (6) @(posedge clk);
            #1;
            check("overflow_err_pulses", 32'(err_pulses - e0), 32'd1);
            check("overflow_idle", 32'(busy), 32'd0);
        end
        pl = {8'hA5, 8'h5A, 8'hC3};
        push_frame(pl, 8'h22, 1'b0, 8'h00);
        send(pl, 8'h22, 1'b0, 8'h00, 1'b0);
        drain("after_overflow");

        // Random downstream stalls
        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pl = {8'h41};
            push_frame(pl, 8'h01, k[0], 8'h11);
            send(pl, 8'h01, k[0], 8'h11, 1'b0);
            drain("stall");
        end
        stall_en = 1'b0;

        // Reset while emitting payload
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(8'(8'h90 + i));
        push_frame(pl, 8'h44, 1'b0, 8'h00);
        h0 = hs_count;
        send(pl, 8'h44, 1'b0, 8'h00, 1'b0);
        w = 0;
        while (hs_count < h0 + 6 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reach_payload", 32'(hs_count >= h0 + 6), 32'd1);
        e0 = err_pulses;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        expq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("release_tready", 32'(prsp.tready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        pl = {8'h41};
        push_frame(pl, 8'h01, 1'b0, 8'h00);
        send(pl, 8'h01, 1'b0, 8'h00, 1'b0);
        drain("after_reset");
        check("midreset_no_err", 32'(err_pulses - e0), 32'd0);

        // Back-to-back frames with payload tvalid held high
        pl  = {8'h11};
        pl2 = {8'h22};
        push_frame(pl, 8'h05, 1'b0, 8'h00);
        push_frame(pl2, 8'h06, 1'b0, 8'h00);
        send(pl, 8'h05, 1'b0, 8'h00, 1'b1);
        send(pl2, 8'h06, 1'b0, 8'h00, 1'b0);
        drain("b2b");
        check("b2b_gap", 32'(gap), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
